seq_detector_p: RTL

SEQ_DETECTOR_P -- requirements
Module: seq_detector_p

---
 rtl/seq_detector_p.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seq_detector_p.sv
//==============================================================================
// Module   : seq_detector_p
// Purpose  : Loadable N-symbol pattern detector with optional overlapping
//            matches and a saturating match counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_detector_p #(
    parameter int W  = 2,
    parameter int N  = 3,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  num,
    input  logic          valid,
    input  logic          load,
    input  logic [W-1:0]  pat_in,
    input  logic          overlap,
    output logic          ans,
    output logic [CW-1:0] match_cnt,
    output logic          armed
);

    localparam int IW = $clog2(N);
    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] C_FILL_FULL = FW'(N);
    localparam logic [IW-1:0] C_IDX_LAST  = IW'(N - 1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_ARMED   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [FW-1:0]          fill_q, fill_d;
    // Pattern is stored reversed (p[0] at the top) so it lines up with the
    // history, whose newest symbol sits at index 0.
    logic [N-1:0][W-1:0]    pat_q, pat_d;
    logic [N-1:0][W-1:0]    hist_q, hist_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ans_q, ans_d;
    logic                   armed_q;

    logic [N-1:0][W-1:0]    w_hist_sh;
    logic [FW-1:0]          w_fill_sh;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        hist_d    = hist_q;
        cnt_d     = cnt_q;
        ans_d     = 1'b0;
        w_hist_sh = {hist_q[N-2:0], num};
        w_fill_sh = (fill_q == C_FILL_FULL) ? fill_q : fill_q + 1'b1;

        unique case (state_q)
            S_EMPTY, S_ARMED: begin
                if (load) begin
                    pat_d[N-1] = pat_in;
                    idx_d      = IW'(1);
                    fill_d     = '0;
                    cnt_d      = '0;
                    state_d    = S_LOADING;
                end else if (state_q == S_ARMED && valid) begin
                    hist_d = w_hist_sh;
                    fill_d = w_fill_sh;
                    if (w_fill_sh == C_FILL_FULL && w_hist_sh == pat_q) begin
                        ans_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (!overlap) begin
                            fill_d = '0;
                        end
                    end
                end
            end
            S_LOADING: begin
                if (load) begin
                    for (int k = 0; k < N; k++) begin
                        if (k == N - 1 - int'(idx_q)) begin
                            pat_d[k] = pat_in;
                        end
                    end
                    if (idx_q == C_IDX_LAST) begin
                        state_d = S_ARMED;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            idx_q   <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            hist_q  <= '0;
            cnt_q   <= '0;
            ans_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            ans_q   <= ans_d;
            armed_q <= (state_d == S_ARMED);
        end
    end

    assign ans       = ans_q;
    assign match_cnt = cnt_q;
    assign armed     = armed_q;

endmodule

`default_nettype wire
